// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory-stage control bit positions and FSM states.
package mips_pkg;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;
  localparam int M_W      = 3;
  localparam int WB_W     = 2;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read, contents not reset.
module data_memory #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: data access with wait states, branch resolution, MEM/WB register.
// Holds the pipeline via stall while a load/store waits; reset aborts a pending access.
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WB_W-1:0]   EX_MEM_wb_ctlout,
  input  logic [M_W-1:0]    EX_MEM_m_ctlout,
  input  logic [31:0]       EX_MEM_add_result,
  input  logic              EX_MEM_zero,
  input  logic [31:0]       EX_MEM_alu_result,
  input  logic [31:0]       EX_MEM_rdata2out,
  input  logic [4:0]        EX_MEM_five_bit_muxout,
  output logic              MEM_PCSrc,
  output logic [31:0]       MEM_branch_target,
  output logic              stall,
  output logic [WB_W-1:0]   MEM_WB_wb_ctlout,
  output logic [31:0]       MEM_WB_read_data,
  output logic [31:0]       MEM_WB_alu_result,
  output logic [4:0]        MEM_WB_five_bit_muxout
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS_L = CW'(WAIT_STATES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          memread, memwrite, access, complete, we;
  logic [31:0]   rdata, load_data;
  logic          unused_addr_bits;

  assign memread  = EX_MEM_m_ctlout[MEMREAD];
  assign memwrite = EX_MEM_m_ctlout[MEMWRITE];
  assign access   = memread | memwrite;

  // An instruction retires this edge unless it is an access still waiting out its latency.
  assign complete = !access || (WAIT_STATES == 0) || (state == WAIT && cnt == WS_L);
  assign stall    = !complete;
  assign we       = memwrite && complete && !reset;

  assign MEM_PCSrc         = EX_MEM_m_ctlout[BRANCH] & EX_MEM_zero;
  assign MEM_branch_target = EX_MEM_add_result;

  // A simultaneous read+write is treated as a store, so it returns no load data.
  assign load_data = (memread && !memwrite) ? rdata : 32'h0;

  assign unused_addr_bits = ^{EX_MEM_alu_result[31:AW+2], EX_MEM_alu_result[1:0]};

  data_memory #(.DEPTH(MEM_DEPTH)) u_dmem (
    .clk   (clk),
    .we    (we),
    .addr  (EX_MEM_alu_result[AW+1:2]),
    .wdata (EX_MEM_rdata2out),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                  <= IDLE;
      cnt                    <= '0;
      MEM_WB_wb_ctlout       <= '0;
      MEM_WB_read_data       <= '0;
      MEM_WB_alu_result      <= '0;
      MEM_WB_five_bit_muxout <= '0;
    end else if (complete) begin
      state                  <= IDLE;
      cnt                    <= '0;
      MEM_WB_wb_ctlout       <= EX_MEM_wb_ctlout;
      MEM_WB_read_data       <= load_data;
      MEM_WB_alu_result      <= EX_MEM_alu_result;
      MEM_WB_five_bit_muxout <= EX_MEM_five_bit_muxout;
    end else begin
      state                  <= WAIT;
      cnt                    <= (state == IDLE) ? CW'(1) : cnt + CW'(1);
      MEM_WB_wb_ctlout       <= '0;
      MEM_WB_read_data       <= '0;
      MEM_WB_alu_result      <= '0;
      MEM_WB_five_bit_muxout <= '0;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized transaction-level check of mem_stage against a behavioural model with directed corner cases.
module tb_mem_stage;
  localparam int DEPTH = 256;
  localparam int WS    = 2;

  logic        clk = 0;
  logic        reset;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [31:0] add_r, alu, wdata;
  logic        zero;
  logic [4:0]  rd;
  logic        pcsrc, stall;
  logic [31:0] target, o_rdata, o_alu;
  logic [1:0]  o_wb;
  logic [4:0]  o_rd;

  int vectors = 0;
  int errors  = 0;

  // Model state: memory image and the result the next edge will present in MEM/WB.
  logic [31:0] mem_m [DEPTH];
  logic [1:0]  exp_wb;
  logic [31:0] exp_rdata, exp_alu, exp_target;
  logic [4:0]  exp_rd;
  logic        exp_stall, exp_pcsrc;
  logic [70:0] last_res;
  bit          chk = 0;

  mem_stage #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset),
    .EX_MEM_wb_ctlout(wb), .EX_MEM_m_ctlout(m), .EX_MEM_add_result(add_r),
    .EX_MEM_zero(zero), .EX_MEM_alu_result(alu), .EX_MEM_rdata2out(wdata),
    .EX_MEM_five_bit_muxout(rd),
    .MEM_PCSrc(pcsrc), .MEM_branch_target(target), .stall(stall),
    .MEM_WB_wb_ctlout(o_wb), .MEM_WB_read_data(o_rdata),
    .MEM_WB_alu_result(o_alu), .MEM_WB_five_bit_muxout(o_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("stall",   {31'b0, stall}, {31'b0, exp_stall});
      check("pcsrc",   {31'b0, pcsrc}, {31'b0, exp_pcsrc});
      check("target",  target, exp_target);
      check("mwb_wb",  {30'b0, o_wb}, {30'b0, exp_wb});
      check("mwb_rd",  {27'b0, o_rd}, {27'b0, exp_rd});
      check("mwb_alu", o_alu, exp_alu);
      check("mwb_rdata", o_rdata, exp_rdata);
    end
  end

  // Present one instruction, holding it for as long as the model says the access lasts.
  task automatic issue(input logic [1:0] i_wb, input logic [2:0] i_m, input logic [31:0] i_add,
                       input logic i_zero, input logic [31:0] i_alu, input logic [31:0] i_wd,
                       input logic [4:0] i_rd);
    int n;
    int idx;
    logic [31:0] rdv;
    n   = (i_m[1] || i_m[0]) ? WS + 1 : 1;
    idx = int'((i_alu / 4) % DEPTH);
    rdv = (i_m[1] && !i_m[0]) ? mem_m[idx] : 32'h0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      wb = i_wb; m = i_m; add_r = i_add; zero = i_zero; alu = i_alu; wdata = i_wd; rd = i_rd;
      exp_stall  = (k < n - 1);
      exp_pcsrc  = i_m[2] && i_zero;
      exp_target = i_add;
      if (k == 0) {exp_wb, exp_rdata, exp_alu, exp_rd} = last_res;
      else        {exp_wb, exp_rdata, exp_alu, exp_rd} = '0;
      chk = 1;
      @(negedge clk); #1;
    end
    last_res = {i_wb, rdv, i_alu, i_rd};
    if (i_m[0]) mem_m[idx] = i_wd;
  endtask

  task automatic nop();
    issue(2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    reset = 1; wb = 0; m = 0; add_r = 0; zero = 0; alu = 0; wdata = 0; rd = 0;
    last_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_wb",    {30'b0, o_wb}, 32'h0);
    check("rst_alu",   o_alu, 32'h0);
    check("rst_rdata", o_rdata, 32'h0);
    check("rst_rd",    {27'b0, o_rd}, 32'h0);
    @(posedge clk); #1 reset = 0;

    // Non-memory op reaches MEM/WB after one cycle, never stalls.
    issue(2'b10, 3'b000, 32'h0, 1'b0, 32'h1234, 32'h0, 5'd5);
    nop();
    check("lit_alu", o_alu, 32'h1234);
    check("lit_rd",  {27'b0, o_rd}, 32'd5);
    check("lit_wb",  {30'b0, o_wb}, 32'h2);

    // Store then load through the wait states.
    issue(2'b00, 3'b001, 32'h0, 1'b0, 32'h40, 32'hDEADBEEF, 5'd0);
    issue(2'b01, 3'b010, 32'h0, 1'b0, 32'h40, 32'h0, 5'd7);
    nop();
    check("lit_load", o_rdata, 32'hDEADBEEF);

    // Branch resolution is combinational and independent of the FSM.
    issue(2'b00, 3'b100, 32'h100, 1'b1, 32'h0, 32'h0, 5'd0);
    check("lit_pcsrc1",  {31'b0, pcsrc}, 32'h1);
    check("lit_target",  target, 32'h100);
    check("lit_brstall", {31'b0, stall}, 32'h0);
    issue(2'b00, 3'b100, 32'h100, 1'b0, 32'h0, 32'h0, 5'd0);
    check("lit_pcsrc0",  {31'b0, pcsrc}, 32'h0);

    // Addresses wrap modulo depth; byte offset bits are ignored.
    issue(2'b00, 3'b001, 32'h0, 1'b0, 32'h400, 32'h11, 5'd0);
    issue(2'b01, 3'b010, 32'h0, 1'b0, 32'h000, 32'h0, 5'd1);
    nop();
    check("lit_wrap", o_rdata, 32'h11);
    issue(2'b01, 3'b010, 32'h0, 1'b0, 32'h403, 32'h0, 5'd1);
    nop();
    check("lit_lowbits", o_rdata, 32'h11);

    // Read and write together behaves as a store with zero load data.
    issue(2'b01, 3'b011, 32'h0, 1'b0, 32'h10, 32'h77, 5'd2);
    nop();
    check("lit_both_rdata", o_rdata, 32'h0);
    issue(2'b01, 3'b010, 32'h0, 1'b0, 32'h10, 32'h0, 5'd2);
    nop();
    check("lit_both_load", o_rdata, 32'h77);

    // Reset in the first wait cycle of a store must drop the write.
    issue(2'b00, 3'b001, 32'h0, 1'b0, 32'h80, 32'hAA, 5'd0);
    @(posedge clk); #1;
    chk = 0;
    m = 3'b001; alu = 32'h80; wdata = 32'h55; wb = 0; rd = 0; zero = 0; add_r = 0;
    @(negedge clk);
    check("rstw_stall1", {31'b0, stall}, 32'h1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1;
    reset = 0; m = 0; alu = 0; wdata = 0;
    @(negedge clk);
    check("rstw_stall0", {31'b0, stall}, 32'h0);
    check("rstw_wb",     {30'b0, o_wb}, 32'h0);
    check("rstw_alu",    o_alu, 32'h0);
    last_res = '0;
    issue(2'b01, 3'b010, 32'h0, 1'b0, 32'h80, 32'h0, 5'd3);
    nop();
    check("rstw_load", o_rdata, 32'hAA);

    // Fill every location so random loads always hit known data.
    for (int i = 0; i < DEPTH; i++)
      issue(2'b00, 3'b001, 32'h0, 1'b0, 32'(i * 4), $urandom, 5'd0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] mm;
      case ($urandom_range(0, 4))
        0: mm = 3'b000;
        1: mm = 3'b100;
        2: mm = 3'b010;
        3: mm = 3'b001;
        default: mm = 3'b011;
      endcase
      issue(2'($urandom), mm, $urandom, 1'($urandom), $urandom, $urandom, 5'($urandom));
    end
    nop();
    nop();
    chk = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
